frame_dma_sched: RTL and testbench
==================================

# frame_dma_sched

Per-frame scheduler for the HDMI scan-out path. It issues one MM2S DMA command per video frame, aligned to the pixel timing's `frame_end` pulse, so the pixel FIFO is refilled with exactly one frame of 32-bit pixels (`{8'h0, B, G, R}`). It manages a double-buffered framebuffer: CPU swap requests take effect only at a frame boundary, never mid-frame. It also reports completion, errors and late frames to the MicroBlaze register block.

## Interface
Parameters:
- `ADDR_W`, 32, width of DMA byte address.
- `LEN_W`, 23, width of DMA byte-length field.
- `FRAME_BYTES`, 1228800, bytes per frame (640×480×4); must fit in `LEN_W`.

Ports:
- `clk`  in  1  pixel clock; the same clock as the timing generator.
- `rstn`  in  1  synchronous, active-low reset.
- `enable`  in  1  level; scheduling is allowed while high.
- `frame_end`  in  1  one-cycle pulse from the timing generator at the end of the visible frame.
- `base0`, `base1`  in  `ADDR_W`  framebuffer byte addresses; sampled only when a command is built.
- `swap_req`  in  1  one-cycle pulse; requests a swap of the front buffer.
- `err_clr`  in  1  one-cycle pulse; clears `err`.
- `cmd_valid`  out  1  DMA command valid.
- `cmd_ready`  in  1  DMA command ready.
- `cmd_addr`  out  `ADDR_W`  start address of the command.
- `cmd_len`  out  `LEN_W`  command length; constant `FRAME_BYTES`.
- `sts_valid`  in  1  DMA status valid.
- `sts_ok`  in  1  DMA status; 1 = OKAY, 0 = error.
- `sts_ready`  out  1  status accept.
- `front_sel`  out  1  current front buffer; 0 = `base0`.
- `swap_ack`  out  1  one-cycle pulse when a swap takes effect.
- `irq`  out  1  one-cycle pulse on each completed frame transfer, whether OK or error.
- `busy`  out  1  high in ISSUE or XFER.
- `err`  out  1  sticky DMA-error flag.
- `frame_cnt`  out  16  count of successful transfers; wraps.
- `late_cnt`  out  8  count of missed frame boundaries; saturates at 255.

## Operation
States and transitions:
- **IDLE**: no command activity. Goes to WAIT_FE when `enable`=1.
- **WAIT_FE**: waits for a frame boundary.
  - If `enable`=0, goes to IDLE.
  - On `frame_end`: applies a pending swap if `swap_pend | swap_req` (toggles `front_sel`, pulses `swap_ack`, clears `swap_pend`). Then registers `cmd_addr` from the new `front_sel` (`base1` if 1, else `base0`) and goes to ISSUE.
- **ISSUE**: `cmd_valid`=1, with `cmd_addr`/`cmd_len` held stable. On `cmd_valid & cmd_ready`, goes to XFER. `cmd_valid` never drops before the handshake, even if `enable` falls.
- **XFER**: `sts_ready`=1. On `sts_valid`: pulse `irq`. If `sts_ok`, increment `frame_cnt`; otherwise set `err`. Then go to WAIT_FE, or to IDLE if `enable`=0.

Swap and counter rules:
- `swap_pend` is set by `swap_req` in any state. A `swap_req` while already pending is absorbed: one swap only.
- `frame_end` while in ISSUE or XFER (including the same cycle as the `sts_valid` handshake) increments `late_cnt` (saturating). That boundary is not re-armed; the next command waits for the following `frame_end`.
- `err_clr` clears `err`. If `err_clr` and a setting error occur in the same cycle, set wins.
- `frame_end` in IDLE is ignored.

## Timing
- Reset values: state IDLE, `cmd_valid`=0, `cmd_addr`=0, `sts_ready`=0, `front_sel`=0, `swap_pend`=0, `swap_ack`=0, `irq`=0, `busy`=0, `err`=0, `frame_cnt`=0, `late_cnt`=0. Reset mid-transfer abandons the transfer immediately; the DMA is reset alongside.
- `enable` rising at cycle N: WAIT_FE at N+1. The first command follows the next `frame_end`.
- `frame_end` at cycle N in WAIT_FE: `cmd_valid`=1 at N+1. `swap_ack` pulses at N+1 if a swap was applied. `front_sel` is updated at N+1.
- Handshake at cycle M (`cmd_valid & cmd_ready`): `cmd_valid`=0 and `sts_ready`=1 at M+1.
- `sts_valid` accepted at cycle K: `irq`=1 at K+1 for exactly one cycle. Counters and `err` are updated at K+1. State is WAIT_FE at K+1, so a `frame_end` at K+1 is served.
- `cmd_len` = `FRAME_BYTES`, constant and truncated to `LEN_W`. All outputs are registered.

## Test plan
- **Basic frames.** Stimulus: reset, `enable`=1, `base0`=0x8000_0000, `frame_end` every 1000 cycles, `cmd_ready`=1, OK status 200 cycles after each command. Response: one command per `frame_end` with `cmd_addr`=0x8000_0000 and `cmd_len`=1228800; `irq`×3 and `frame_cnt`=3 after 3 frames; `late_cnt`=0.
- **Swap.** Stimulus: `swap_req` pulsed twice mid-transfer, `base1`=0x8012_C000. Response: exactly one `swap_ack`, coincident with the cycle after the next `frame_end`; `front_sel`=1; the next `cmd_addr`=0x8012_C000.
- **Backpressure.** Stimulus: `cmd_ready` held low for 50 cycles, with `enable` dropped meanwhile. Response: `cmd_valid` and `cmd_addr` stay stable until the handshake; after the status, state is IDLE and `busy`=0.
- **Late frame.** Stimulus: status delayed past two `frame_end` pulses. Response: `late_cnt`=2, no extra command; the next command is issued after the following `frame_end`.
- **Error.** Stimulus: `sts_ok`=0. Response: `err`=1, `irq` pulses, `frame_cnt` unchanged. `err_clr` coincident with another error leaves `err`=1; a lone `err_clr` clears it.
- **Saturation and reset.** Stimulus: 300 late events, then `rstn`=0 during XFER. Response: `late_cnt`=255 before reset; all outputs at their reset values one cycle after reset.

Source files
------------

// File: rtl/frame_dma_sched_if.sv
// DMA command/status channel between the frame scheduler (master) and the MM2S DMA (slave).
interface frame_dma_sched_if #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 23
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              sts_valid;
  logic              sts_ok;
  logic              sts_ready;

  modport master (
    output cmd_valid, cmd_addr, cmd_len, sts_ready,
    input  cmd_ready, sts_valid, sts_ok
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, sts_ready,
    output cmd_ready, sts_valid, sts_ok
  );
endinterface

// File: rtl/frame_dma_sched.sv
// Issues one MM2S command per frame at frame_end, double-buffers the framebuffer
// with boundary-aligned swaps, and reports completion, errors and late frames.
module frame_dma_sched #(
  parameter int ADDR_W      = 32,
  parameter int LEN_W       = 23,
  parameter int FRAME_BYTES = 1228800
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enable,
  input  logic              frame_end,
  input  logic [ADDR_W-1:0] base0,
  input  logic [ADDR_W-1:0] base1,
  input  logic              swap_req,
  input  logic              err_clr,
  frame_dma_sched_if.master dma,
  output logic              front_sel,
  output logic              swap_ack,
  output logic              irq,
  output logic              busy,
  output logic              err,
  output logic [15:0]       frame_cnt,
  output logic [7:0]        late_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_FE = 2'd1,
    S_ISSUE   = 2'd2,
    S_XFER    = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic              r_cmd_valid, r_sts_ready, r_front, r_swap_pend, r_swap_ack;
  logic              r_irq, r_busy, r_err;
  logic [ADDR_W-1:0] r_cmd_addr;
  logic [15:0]       r_frame_cnt;
  logic [7:0]        r_late_cnt;

  logic              w_fire, w_swap_do, w_done, w_ok, w_late, w_front_nxt;

  // Next-state and per-cycle event decode.
  always_comb begin
    w_state_nxt = r_state;
    w_fire      = 1'b0;
    w_swap_do   = 1'b0;
    w_done      = 1'b0;
    w_ok        = 1'b0;
    w_late      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable) w_state_nxt = S_WAIT_FE;
        else        w_state_nxt = S_IDLE;
      end
      S_WAIT_FE: begin
        if (!enable) begin
          w_state_nxt = S_IDLE;
        end else if (frame_end) begin
          w_state_nxt = S_ISSUE;
          w_fire      = 1'b1;
          w_swap_do   = r_swap_pend | swap_req;
        end else begin
          w_state_nxt = S_WAIT_FE;
        end
      end
      S_ISSUE: begin
        w_late = frame_end;
        // enable is deliberately ignored here: a presented command must complete its handshake
        if (r_cmd_valid && dma.cmd_ready) w_state_nxt = S_XFER;
        else                              w_state_nxt = S_ISSUE;
      end
      S_XFER: begin
        w_late = frame_end;
        if (r_sts_ready && dma.sts_valid) begin
          w_done      = 1'b1;
          w_ok        = dma.sts_ok;
          w_state_nxt = enable ? S_WAIT_FE : S_IDLE;
        end else begin
          w_state_nxt = S_XFER;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_front_nxt = r_front ^ w_swap_do;

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_cmd_valid <= 1'b0;
      r_cmd_addr  <= {ADDR_W{1'b0}};
      r_sts_ready <= 1'b0;
      r_front     <= 1'b0;
      r_swap_pend <= 1'b0;
      r_swap_ack  <= 1'b0;
      r_irq       <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_frame_cnt <= 16'd0;
      r_late_cnt  <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_valid <= (w_state_nxt == S_ISSUE);
      r_sts_ready <= (w_state_nxt == S_XFER);
      r_busy      <= (w_state_nxt == S_ISSUE) || (w_state_nxt == S_XFER);
      r_front     <= w_front_nxt;
      r_swap_ack  <= w_swap_do;
      // a request arriving on the very boundary that applies a swap is consumed by it
      r_swap_pend <= w_swap_do ? 1'b0 : (r_swap_pend | swap_req);
      r_irq       <= w_done;
      if (w_fire) r_cmd_addr <= w_front_nxt ? base1 : base0;
      else        r_cmd_addr <= r_cmd_addr;
      if (w_done && w_ok) r_frame_cnt <= r_frame_cnt + 16'd1;
      else                r_frame_cnt <= r_frame_cnt;
      if (w_late && (r_late_cnt != 8'hFF)) r_late_cnt <= r_late_cnt + 8'd1;
      else                                 r_late_cnt <= r_late_cnt;
      if (w_done && !w_ok) r_err <= 1'b1;
      else if (err_clr)    r_err <= 1'b0;
      else                 r_err <= r_err;
    end
  end

  assign dma.cmd_valid = r_cmd_valid;
  assign dma.cmd_addr  = r_cmd_addr;
  assign dma.cmd_len   = LEN_W'(FRAME_BYTES);
  assign dma.sts_ready = r_sts_ready;
  assign front_sel     = r_front;
  assign swap_ack      = r_swap_ack;
  assign irq           = r_irq;
  assign busy          = r_busy;
  assign err           = r_err;
  assign frame_cnt     = r_frame_cnt;
  assign late_cnt      = r_late_cnt;

endmodule

// File: tb/tb_frame_dma_sched.sv
// Directed bench for frame_dma_sched: expected command addresses are queued when a
// frame boundary is driven and popped when the DMA handshake is observed.
module tb_frame_dma_sched;

  logic        clk = 1'b0;
  logic        rstn, enable, frame_end, swap_req, err_clr;
  logic [31:0] base0, base1;
  logic        front_sel, swap_ack, irq, busy, err;
  logic [15:0] frame_cnt;
  logic [7:0]  late_cnt;

  frame_dma_sched_if #(.ADDR_W(32), .LEN_W(23)) dma_if ();

  frame_dma_sched #(.ADDR_W(32), .LEN_W(23), .FRAME_BYTES(1228800)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .frame_end(frame_end),
    .base0(base0), .base1(base1), .swap_req(swap_req), .err_clr(err_clr),
    .dma(dma_if), .front_sel(front_sel), .swap_ack(swap_ack), .irq(irq),
    .busy(busy), .err(err), .frame_cnt(frame_cnt), .late_cnt(late_cnt)
  );

  always #5 clk = ~clk;

  logic [31:0] exp_q[$];
  int checks = 0, failures = 0;
  int n_irq = 0, n_swap = 0;
  int exp_frames = 0, exp_irq = 0, exp_late = 0;

  // Pulse counters for irq and swap_ack.
  always @(posedge clk) begin
    if (irq)      n_irq  <= n_irq + 1;
    if (swap_ack) n_swap <= n_swap + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_fe();
    frame_end = 1'b1;
    cyc(1);
    frame_end = 1'b0;
  endtask

  task automatic fe_cmd(input logic [31:0] addr);
    exp_q.push_back(addr);
    pulse_fe();
    chk("cmd_valid_after_fe", 32'(dma_if.cmd_valid), 32'd1);
  endtask

  task automatic wait_cmd();
    bit got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (dma_if.cmd_valid && dma_if.cmd_ready) begin
        got = 1'b1;
        chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("cmd_addr", dma_if.cmd_addr, exp_q.pop_front());
        chk("cmd_len", 32'(dma_if.cmd_len), 32'd1228800);
      end
      cyc(1);
    end
    chk("cmd_timeout", 32'(got), 32'd1);
  endtask

  task automatic send_sts(input logic ok, input logic fe, input logic clr);
    bit rdy = 1'b0;
    for (int i = 0; i < 200 && !rdy; i++) begin
      if (dma_if.sts_ready) rdy = 1'b1;
      else                  cyc(1);
    end
    chk("sts_ready_timeout", 32'(rdy), 32'd1);
    dma_if.sts_valid = 1'b1;
    dma_if.sts_ok    = ok;
    frame_end        = fe;
    err_clr          = clr;
    cyc(1);
    dma_if.sts_valid = 1'b0;
    dma_if.sts_ok    = 1'b1;
    frame_end        = 1'b0;
    err_clr          = 1'b0;
    exp_irq++;
    if (ok) exp_frames++;
    if (fe && exp_late < 255) exp_late++;
    chk("irq_pulse", 32'(irq), 32'd1);
    chk("frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    chk("late_cnt_sts", 32'(late_cnt), 32'(exp_late));
    if (!ok) chk("err_set", 32'(err), 32'd1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cmd_valid"}, 32'(dma_if.cmd_valid), 32'd0);
    chk({tag, "_cmd_addr"},  dma_if.cmd_addr, 32'd0);
    chk({tag, "_sts_ready"}, 32'(dma_if.sts_ready), 32'd0);
    chk({tag, "_front_sel"}, 32'(front_sel), 32'd0);
    chk({tag, "_swap_ack"},  32'(swap_ack), 32'd0);
    chk({tag, "_irq"},       32'(irq), 32'd0);
    chk({tag, "_busy"},      32'(busy), 32'd0);
    chk({tag, "_err"},       32'(err), 32'd0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    chk({tag, "_late_cnt"},  32'(late_cnt), 32'd0);
  endtask

  initial begin
    bit stable;
    rstn = 1'b0; enable = 1'b0; frame_end = 1'b0; swap_req = 1'b0; err_clr = 1'b0;
    base0 = 32'h8000_0000; base1 = 32'h8012_C000;
    dma_if.cmd_ready = 1'b0; dma_if.sts_valid = 1'b0; dma_if.sts_ok = 1'b1;
    cyc(3);
    check_reset("rst0");
    chk("cmd_len_const", 32'(dma_if.cmd_len), 32'd1228800);
    rstn = 1'b1;
    cyc(2);

    // frame_end in IDLE does nothing
    pulse_fe();
    chk("idle_fe_ignored", 32'(dma_if.cmd_valid), 32'd0);
    enable = 1'b1;
    cyc(1);
    chk("wait_fe_not_busy", 32'(busy), 32'd0);
    cyc(5);
    chk("no_cmd_before_fe", 32'(dma_if.cmd_valid), 32'd0);

    // basic frames
    dma_if.cmd_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      cyc(30);
      fe_cmd(base0);
      chk("busy_issue", 32'(busy), 32'd1);
      wait_cmd();
      chk("sts_ready_xfer", 32'(dma_if.sts_ready), 32'd1);
      cyc(20);
      send_sts(1'b1, 1'b0, 1'b0);
      cyc(1);
      chk("irq_one_cycle", 32'(irq), 32'd0);
    end
    chk("basic_frame_cnt", 32'(frame_cnt), 32'd3);
    chk("basic_late_cnt", 32'(late_cnt), 32'd0);
    chk("basic_irq_count", 32'(n_irq), 32'd3);

    // swap requested twice mid-transfer: one swap at the next boundary
    cyc(10);
    fe_cmd(base0);
    wait_cmd();
    swap_req = 1'b1; cyc(1); swap_req = 1'b0;
    cyc(5);
    swap_req = 1'b1; cyc(1); swap_req = 1'b0;
    cyc(5);
    send_sts(1'b1, 1'b0, 1'b0);
    cyc(5);
    chk("swap_not_before_fe", 32'(front_sel), 32'd0);
    chk("swap_ack_none_yet", 32'(n_swap), 32'd0);
    exp_q.push_back(base1);
    pulse_fe();
    chk("swap_ack_pulse", 32'(swap_ack), 32'd1);
    chk("swap_front_sel", 32'(front_sel), 32'd1);
    wait_cmd();
    chk("swap_ack_drop", 32'(swap_ack), 32'd0);
    cyc(10);
    send_sts(1'b1, 1'b0, 1'b0);
    cyc(3);
    chk("swap_ack_once", 32'(n_swap), 32'd1);

    // backpressure with enable dropped while the command is pending
    cyc(10);
    dma_if.cmd_ready = 1'b0;
    fe_cmd(base1);
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cyc(1);
      if (i == 10) enable = 1'b0;
      if (!(dma_if.cmd_valid === 1'b1 && dma_if.cmd_addr === base1)) stable = 1'b0;
    end
    chk("bp_cmd_stable", 32'(stable), 32'd1);
    dma_if.cmd_ready = 1'b1;
    wait_cmd();
    send_sts(1'b1, 1'b0, 1'b0);
    chk("bp_idle_busy", 32'(busy), 32'd0);
    chk("bp_idle_sts_ready", 32'(dma_if.sts_ready), 32'd0);
    cyc(2);
    pulse_fe();
    chk("bp_idle_no_cmd", 32'(dma_if.cmd_valid), 32'd0);

    // late frames: two boundaries during the transfer, a third on the status cycle
    enable = 1'b1;
    cyc(2);
    fe_cmd(base1);
    wait_cmd();
    cyc(5); pulse_fe(); cyc(5); pulse_fe();
    exp_late += 2;
    cyc(2);
    chk("late_cnt_two", 32'(late_cnt), 32'd2);
    chk("late_no_extra_cmd", 32'(dma_if.cmd_valid), 32'd0);
    send_sts(1'b1, 1'b1, 1'b0);
    cyc(4);
    chk("late_not_rearmed", 32'(dma_if.cmd_valid), 32'd0);
    fe_cmd(base1);
    wait_cmd();
    send_sts(1'b1, 1'b0, 1'b0);
    // boundary on the cycle right after status is served
    fe_cmd(base1);
    wait_cmd();

    // errors
    cyc(5);
    send_sts(1'b0, 1'b0, 1'b0);
    fe_cmd(base1);
    wait_cmd();
    send_sts(1'b0, 1'b0, 1'b1);
    chk("err_set_wins_clr", 32'(err), 32'd1);
    cyc(2);
    err_clr = 1'b1; cyc(1); err_clr = 1'b0;
    chk("err_cleared", 32'(err), 32'd0);

    // saturation of late_cnt, then reset mid-transfer
    fe_cmd(base1);
    wait_cmd();
    for (int i = 0; i < 300; i++) begin
      pulse_fe();
      if (exp_late < 255) exp_late++;
      cyc(1);
    end
    chk("late_cnt_sat", 32'(late_cnt), 32'(exp_late));
    chk("late_cnt_255", 32'(late_cnt), 32'd255);
    chk("busy_in_xfer", 32'(busy), 32'd1);
    chk("irq_total", 32'(n_irq), 32'(exp_irq));
    rstn = 1'b0;
    cyc(1);
    check_reset("rst1");
    rstn = 1'b1;
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
